// File: rtl/inverse_cdf_fold_if.sv
// Fixed-point configuration package and the stream bundle between
// the Sobol source, the inverse-CDF fold stage and its consumer.
package fpga_cfg_pkg;
  localparam int FP_WIDTH = 32;
  localparam int FP_QFRAC = 16;
endpackage

interface inverse_cdf_fold_if #(
  parameter int WIDTH = fpga_cfg_pkg::FP_WIDTH,
  parameter int LANES = 4,
  parameter int TAG_W = 8
);
  logic                   valid_in;
  logic                   ready_out;
  logic [LANES*WIDTH-1:0] u;
  logic [TAG_W-1:0]       tag_in;
  logic                   valid_out;
  logic                   ready_in;
  logic [LANES*WIDTH-1:0] x;
  logic [LANES-1:0]       negate;
  logic [LANES-1:0]       range_err;
  logic [TAG_W-1:0]       tag_out;

  modport slave (
    input  valid_in, u, tag_in, ready_in,
    output ready_out, valid_out, x, negate,
    output range_err, tag_out
  );

  modport master (
    output valid_in, u, tag_in, ready_in,
    input  ready_out, valid_out, x, negate,
    input  range_err, tag_out
  );
endinterface

// File: rtl/inverse_cdf_fold.sv
// Folds uniform samples about 1/2 for a symmetric inverse CDF,
// with a registered output plus one skid entry and a clamp counter.
module inverse_cdf_fold
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC,
  parameter int LANES = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  inverse_cdf_fold_if.slave  s,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   clamp_cnt
);

  localparam logic signed [WIDTH-1:0] EPS =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] ONE = EPS << QFRAC;
  localparam logic signed [WIDTH-1:0] HALF = ONE >> 1;
  localparam logic signed [WIDTH:0] ONE1 = {1'b0, ONE};
  localparam int PW = LANES*WIDTH + 2*LANES + TAG_W;

  logic [LANES*WIDTH-1:0] w_x;
  logic [LANES-1:0]       w_neg;
  logic [LANES-1:0]       w_rerr;
  logic [LANES-1:0]       w_clamp;
  logic [PW-1:0]          w_beat;
  logic                   w_in;
  logic [CNT_W:0]         w_sum;

  logic [PW-1:0]    r_out;
  logic [PW-1:0]    r_skid;
  logic             r_ovld;
  logic             r_svld;
  logic             r_rdy;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [WIDTH-1:0] w_u;
    logic                    w_le0;

    assign w_u = s.u[g*WIDTH +: WIDTH];
    assign w_le0 = w_u[WIDTH-1] || (w_u == '0);
    assign w_clamp[g] = w_le0 || (w_u >= ONE);
    assign w_neg[g] = !w_le0 && (w_u >= HALF);
    assign w_rerr[g] = w_u[WIDTH-1] || (w_u > ONE);
    // ONE-u done one bit wider so the sign of u cannot wrap it
    assign w_x[g*WIDTH +: WIDTH] =
      w_clamp[g]  ? EPS :
      (w_u < HALF) ? w_u :
      WIDTH'(ONE1 - {w_u[WIDTH-1], w_u});
  end

  assign w_beat = {w_x, w_neg, w_rerr, s.tag_in};
  assign w_in = s.valid_in && r_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
      r_ovld <= 1'b0;
      r_svld <= 1'b0;
      r_rdy  <= 1'b0;
    end else begin
      r_rdy <= !r_svld || s.ready_in;
      if (r_svld) begin
        if (s.ready_in) begin
          r_out  <= r_skid;
          r_svld <= 1'b0;
        end
      end else if (!r_ovld || s.ready_in) begin
        r_ovld <= w_in;
        if (w_in) r_out <= w_beat;
      end else if (w_in) begin
        r_skid <= w_beat;
        r_svld <= 1'b1;
        r_rdy  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, r_cnt};
    for (int i = 0; i < LANES; i++)
      w_sum = w_sum + (CNT_W+1)'(w_clamp[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_in) begin
      r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
  end

  assign s.valid_out = r_ovld;
  assign s.ready_out = r_rdy;
  assign {s.x, s.negate, s.range_err, s.tag_out} = r_out;
  assign clamp_cnt = r_cnt;

endmodule

// File: tb/tb_inverse_cdf_fold.sv
// Directed bench for inverse_cdf_fold: fold values, skid behaviour,
// clamp counter saturation and asynchronous reset.
module tb_inverse_cdf_fold;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr_cnt = 1'b0;
  logic [15:0] clamp_cnt;

  int n_tests = 0;
  int n_fail = 0;

  inverse_cdf_fold_if #(.WIDTH(32), .LANES(4), .TAG_W(8)) bus ();

  inverse_cdf_fold #(
    .WIDTH(32), .QFRAC(16), .LANES(4), .TAG_W(8), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus),
    .clr_cnt   (clr_cnt),
    .clamp_cnt (clamp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lanes4(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] c,
                                          input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          q[$];
  int          sent, got, cyc, acc, stall;
  logic        p_rin, p_rout, inx, outx;
  logic [31:0] pat;

  initial begin
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    bus.u = '0;
    bus.tag_in = '0;
    #1 rst_n = 1'b0;
    #7;
    chk("rst_valid", 128'(bus.valid_out), 128'd0);
    chk("rst_ready", 128'(bus.ready_out), 128'd0);
    chk("rst_x", bus.x, 128'd0);
    chk("rst_cnt", 128'(clamp_cnt), 128'd0);
    #14 rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 128'(bus.ready_out), 128'd0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", 128'(bus.ready_out), 128'd1);

    // basic fold
    bus.u = lanes4(32'h2000, 32'h8000, 32'hC000, 32'h0001);
    bus.tag_in = 8'h11;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    chk("b1_valid", 128'(bus.valid_out), 128'd1);
    chk("b1_x", bus.x, lanes4(32'h2000, 32'h8000, 32'h4000, 32'h1));
    chk("b1_neg", 128'(bus.negate), 128'b0110);
    chk("b1_rerr", 128'(bus.range_err), 128'd0);
    chk("b1_tag", 128'(bus.tag_out), 128'h11);
    chk("b1_cnt", 128'(clamp_cnt), 128'd0);

    // clamp edges
    bus.u = lanes4(32'h0, 32'h10000, 32'hFFFF_FFFF, 32'h10001);
    bus.tag_in = 8'h22;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    chk("b2_x", bus.x, lanes4(32'h1, 32'h1, 32'h1, 32'h1));
    chk("b2_neg", 128'(bus.negate), 128'b1010);
    chk("b2_rerr", 128'(bus.range_err), 128'b1100);
    chk("b2_tag", 128'(bus.tag_out), 128'h22);
    chk("b2_cnt", 128'(clamp_cnt), 128'd4);

    // values next to HALF/ONE and most negative input
    bus.u = lanes4(32'h7FFF, 32'h8001, 32'hFFFF, 32'h8000_0000);
    bus.tag_in = 8'h33;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    chk("b3_x", bus.x, lanes4(32'h7FFF, 32'h7FFF, 32'h1, 32'h1));
    chk("b3_neg", 128'(bus.negate), 128'b0110);
    chk("b3_rerr", 128'(bus.range_err), 128'b1000);
    chk("b3_cnt", 128'(clamp_cnt), 128'd5);
    tick();
    chk("b3_drain", 128'(bus.valid_out), 128'd0);

    // downstream stall with continuous offers
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      bus.u = {4{32'h1000 + 32'(k)}};
      bus.tag_in = 8'h40 + 8'(k);
      bus.valid_in = 1'b1;
      bus.ready_in = 1'b0;
      chk("st_rdy", 128'(bus.ready_out), 128'(k < 2));
      if (bus.ready_out) acc++;
      tick();
      chk("st_tag", 128'(bus.tag_out), 128'h40);
      chk("st_x0", 128'(bus.x[31:0]), 128'h1000);
    end
    chk("st_acc", 128'(acc), 128'd2);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    tick();
    chk("st_d1_valid", 128'(bus.valid_out), 128'd1);
    chk("st_d1_tag", 128'(bus.tag_out), 128'h41);
    chk("st_d1_x0", 128'(bus.x[31:0]), 128'h1001);
    chk("st_d1_rdy", 128'(bus.ready_out), 128'd1);
    tick();
    chk("st_d2_valid", 128'(bus.valid_out), 128'd0);

    // 16-beat stream with a fixed ready_in pattern
    pat = 32'hB2E5_9C6B;
    sent = 0;
    got = 0;
    cyc = 0;
    bus.valid_in = 1'b1;
    bus.tag_in = 8'h80;
    bus.u = {4{32'h100}};
    bus.ready_in = pat[0];
    while (got < 16 && cyc < 200) begin
      inx = bus.valid_in && bus.ready_out;
      outx = bus.valid_out && bus.ready_in;
      if (outx) begin
        chk("str_tag", 128'(bus.tag_out), 128'(8'h80 + 8'(q[0])));
        chk("str_x0", 128'(bus.x[31:0]), 128'(32'h100 + 32'(q[0])));
        void'(q.pop_front());
        got++;
      end
      if (inx) begin
        q.push_back(sent);
        sent++;
      end
      p_rin = bus.ready_in;
      p_rout = bus.ready_out;
      tick();
      cyc++;
      if (!p_rout && p_rin)
        chk("str_rdy_recover", 128'(bus.ready_out), 128'd1);
      bus.valid_in = (sent < 16);
      bus.tag_in = 8'h80 + 8'(sent);
      bus.u = {4{32'h100 + 32'(sent)}};
      bus.ready_in = pat[cyc[4:0]];
    end
    chk("str_count", 128'(got), 128'd16);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    tick();
    chk("str_cnt", 128'(clamp_cnt), 128'd5);

    // counter clear, fill to 0xFFFE, saturation
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_idle", 128'(clamp_cnt), 128'd0);
    bus.u = '0;
    bus.valid_in = 1'b1;
    stall = 0;
    repeat (16383) begin
      tick();
      if (!bus.ready_out) stall++;
    end
    chk("fill_stalls", 128'(stall), 128'd0);
    bus.u = lanes4(32'h0, 32'h0, 32'h1000, 32'h1000);
    tick();
    chk("cnt_fffe", 128'(clamp_cnt), 128'hFFFE);
    bus.u = '0;
    tick();
    chk("cnt_sat", 128'(clamp_cnt), 128'hFFFF);
    tick();
    chk("cnt_sat_hold", 128'(clamp_cnt), 128'hFFFF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    bus.valid_in = 1'b0;
    chk("clr_prio", 128'(clamp_cnt), 128'd0);
    tick();

    // async reset with a full skid
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b1;
    bus.u = {4{32'h2222}};
    bus.tag_in = 8'h5A;
    tick();
    tick();
    bus.valid_in = 1'b0;
    chk("pre_rst_rdy", 128'(bus.ready_out), 128'd0);
    chk("pre_rst_valid", 128'(bus.valid_out), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(bus.valid_out), 128'd0);
    chk("ar_ready", 128'(bus.ready_out), 128'd0);
    chk("ar_tag", 128'(bus.tag_out), 128'd0);
    chk("ar_x", bus.x, 128'd0);
    bus.ready_in = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_rdy_back", 128'(bus.ready_out), 128'd1);
    for (int k = 0; k < 3; k++) begin
      chk("ar_no_stale", 128'(bus.valid_out), 128'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
